// File: rtl/operand_entry.sv
// -----------------------------------------------------------------------------
// operand_entry
//
// Front-end input stage for the 3-bit adder / bit-count display datapath.
// Synchronizes the switch bank and three pushbuttons, debounces the buttons,
// and latches operand A / operand B from the shared switch bank on presses.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high; clears all state
//   sw       in   [W]  raw switch bank (asynchronous to clk)
//   btn_a    in   raw pushbutton, load operand A (bouncy, active-high)
//   btn_b    in   raw pushbutton, load operand B (bouncy, active-high)
//   btn_clr  in   raw pushbutton, clear both operands (bouncy, active-high)
//   a        out  [W]  registered operand A
//   b        out  [W]  registered operand B
//   upd      out  one-cycle pulse in the first cycle new a/b values are visible
//   ready    out  high while both operands have been loaded since last clear
// -----------------------------------------------------------------------------
module operand_entry #(
  parameter int W        = 3,
  parameter int DB_COUNT = 1000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sw,
  input  logic         btn_a,
  input  logic         btn_b,
  input  logic         btn_clr,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         upd,
  output logic         ready
);

  localparam int            CW      = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_COUNT - 1);

  // Button vector index: 0 = A, 1 = B, 2 = CLR.
  localparam int IDX_A   = 0;
  localparam int IDX_B   = 1;
  localparam int IDX_CLR = 2;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HAVE_A = 2'd1,
    HAVE_B = 2'd2,
    READY  = 2'd3
  } state_t;

  logic [W-1:0]  sw_m_q, sw_s_q;
  logic [2:0]    btn_raw;
  logic [2:0]    btn_m_q, btn_s_q;
  logic [2:0]    db_q, db_dly_q;
  logic [CW-1:0] cnt_q [3];
  logic [2:0]    press;

  state_t        state_q;
  logic [W-1:0]  a_q, b_q;
  logic          upd_q;

  assign btn_raw = {btn_clr, btn_b, btn_a};

  // Two-flop synchronizers on every raw input, including each switch bit.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_m_q  <= '0;
      sw_s_q  <= '0;
      btn_m_q <= '0;
      btn_s_q <= '0;
    end else begin
      sw_m_q  <= sw;
      sw_s_q  <= sw_m_q;
      btn_m_q <= btn_raw;
      btn_s_q <= btn_m_q;
    end
  end

  // Debounce: db follows btn_s only after DB_COUNT consecutive mismatching
  // cycles; any return to agreement restarts the count.
  // NOTE: the counter array is reset explicitly so a reset mid-debounce
  // discards the partial count instead of leaving it to finish afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q     <= '0;
      db_dly_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      db_dly_q <= db_q;
      for (int i = 0; i < 3; i++) begin
        if (btn_s_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          db_q[i]  <= btn_s_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Rising edge of the debounced level only; releases produce nothing.
  assign press = db_q & ~db_dly_q;

  // Operand registers, update strobe and status FSM. Clear wins over loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      upd_q   <= 1'b0;
    end else begin
      upd_q <= |press;
      if (press[IDX_CLR]) begin
        a_q     <= '0;
        b_q     <= '0;
        state_q <= EMPTY;
      end else begin
        if (press[IDX_A]) a_q <= sw_s_q;
        if (press[IDX_B]) b_q <= sw_s_q;
        // Reloading an operand already held leaves the state unchanged.
        case (state_q)
          EMPTY: begin
            if (press[IDX_A] && press[IDX_B]) state_q <= READY;
            else if (press[IDX_A])            state_q <= HAVE_A;
            else if (press[IDX_B])            state_q <= HAVE_B;
          end
          HAVE_A:  if (press[IDX_B]) state_q <= READY;
          HAVE_B:  if (press[IDX_A]) state_q <= READY;
          default: ;  // READY is absorbing until clear
        endcase
      end
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign upd   = upd_q;
  assign ready = (state_q == READY);

endmodule

// File: tb/tb_operand_entry.sv
// -----------------------------------------------------------------------------
// tb_operand_entry
//
// Directed stimulus for operand_entry with DB_COUNT=4. Each issued action
// pushes its expected {a, b, ready, cycle} onto a queue; a separate monitor
// pops and compares whenever the DUT raises upd.
// -----------------------------------------------------------------------------
module tb_operand_entry;

  localparam int W        = 3;
  localparam int DB_COUNT = 4;
  localparam int LAT      = DB_COUNT + 3;  // press capture edge -> upd edge

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw;
  logic         btn_a, btn_b, btn_clr;
  logic [W-1:0] a, b;
  logic         upd, ready;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    int           at_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  operand_entry #(.W(W), .DB_COUNT(DB_COUNT)) dut (
    .clk     (clk),
    .reset   (reset),
    .sw      (sw),
    .btn_a   (btn_a),
    .btn_b   (btn_b),
    .btn_clr (btn_clr),
    .a       (a),
    .b       (b),
    .upd     (upd),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number N, cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every upd pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && upd === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("upd_unexpected", int'(upd), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("upd_cycle", cyc, e.at_cyc);
        check("a", int'(a), int'(e.a));
        check("b", int'(b), int'(e.b));
        check("ready", int'(ready), int'(e.ready));
      end
    end
  end

  // Set sw, let it settle, press the chosen buttons cleanly, hold, release,
  // and let the release debounce before returning.
  task automatic do_press(input logic pa, input logic pb, input logic pc,
                          input logic [W-1:0] swv, input logic [W-1:0] ea,
                          input logic [W-1:0] eb, input logic er);
    exp_t e;
    sw = swv;
    repeat (3) @(negedge clk);
    btn_a = pa; btn_b = pb; btn_clr = pc;
    e.a = ea; e.b = eb; e.ready = er; e.at_cyc = cyc + LAT;
    exp_q.push_back(e);
    repeat (10) @(negedge clk);
    btn_a = 1'b0; btn_b = 1'b0; btn_clr = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset = 1'b1; sw = '0; btn_a = 1'b0; btn_b = 1'b0; btn_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: everything at reset values.
    repeat (20) @(negedge clk);
    check("rst_a", int'(a), 0);
    check("rst_b", int'(b), 0);
    check("rst_upd", int'(upd), 0);
    check("rst_ready", int'(ready), 0);

    // Clean A press, sw=5: a=5, b untouched, not ready.
    do_press(1'b1, 1'b0, 1'b0, 3'd5, 3'd5, 3'd0, 1'b0);
    check("a_hold_b", int'(b), 0);

    // B bouncing 1,0,1,0 every 2 cycles, then held with sw=3.
    sw = 3'd3;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      btn_b = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    btn_b = 1'b1;
    e.a = 3'd5; e.b = 3'd3; e.ready = 1'b1; e.at_cyc = cyc + LAT;
    exp_q.push_back(e);
    repeat (10) @(negedge clk);
    btn_b = 1'b0;
    repeat (12) @(negedge clk);
    check("bounce_ready_level", int'(ready), 1);

    // A and CLR together with sw=7: clear wins.
    do_press(1'b1, 1'b0, 1'b1, 3'd7, 3'd0, 3'd0, 1'b0);

    // Load A, then reload A: stays HAVE_A, not ready.
    do_press(1'b1, 1'b0, 1'b0, 3'd2, 3'd2, 3'd0, 1'b0);
    do_press(1'b1, 1'b0, 1'b0, 3'd4, 3'd4, 3'd0, 1'b0);

    // Clear back to EMPTY.
    do_press(1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 3'd0, 1'b0);

    // A and B together from EMPTY with sw=6: straight to READY.
    do_press(1'b1, 1'b1, 1'b0, 3'd6, 3'd6, 3'd6, 1'b1);

    // Reset 3 cycles into an A debounce; button released during reset.
    sw = 3'd1;
    repeat (3) @(negedge clk);
    btn_a = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_a", int'(a), 0);
    check("midrst_b", int'(b), 0);
    check("midrst_upd", int'(upd), 0);
    check("midrst_ready", int'(ready), 0);
    btn_a = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_a", int'(a), 0);
    check("post_rst_ready", int'(ready), 0);

    check("pending_expects", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
# operand_entry

Front-end input stage for the 3-bit adder/bit-count display datapath. It synchronizes and debounces the board switches and three pushbuttons, and latches operand A and operand B from a shared switch bank on button presses. It presents stable registered operands, a one-cycle update strobe and a ready flag to the adder stage downstream. The adder and 7-segment scanner consume the operand outputs directly.

## Interface
- W, default 3: operand width (switch bank width)
- DB_COUNT, default 1000000: consecutive stable cycles required to accept a button change (20 ms at 50 MHz); must be ≥2
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high; clears all state
- sw  input  W  raw switch bank, asynchronous to clk
- btn_a  input  1  raw pushbutton, load operand A, active-high, bouncy
- btn_b  input  1  raw pushbutton, load operand B, active-high, bouncy
- btn_clr  input  1  raw pushbutton, clear both operands, active-high, bouncy
- a  output  W  registered operand A
- b  output  W  registered operand B
- upd  output  1  one-cycle pulse, high in the first cycle new a/b values are visible
- ready  output  1  high while both operands have been loaded since the last clear/reset

## Operation
- Synchronizers: every raw input, including each sw bit, passes through 2 flip-flops. sw_s and btn_*_s are the second-stage outputs.
- Debounce, one instance per button, with state db, counter cnt of width clog2(DB_COUNT):
  - btn_s == db: cnt <= 0.
  - btn_s != db and cnt < DB_COUNT-1: cnt <= cnt+1.
  - btn_s != db and cnt == DB_COUNT-1: db <= btn_s, cnt <= 0.
  - Net effect: db flips only after DB_COUNT consecutive mismatching cycles. Any glitch back resets cnt.
- Press detect: press_x = db_x & ~db_x_q, where db_x_q is db_x delayed one cycle. Releases generate nothing.
- Actions, registered on the edge after press_x is high:
  - press_clr: a <= 0, b <= 0, status -> EMPTY. This overrides press_a and press_b in the same cycle.
  - press_a: a <= sw_s.
  - press_b: b <= sw_s.
  - press_a and press_b in the same cycle: both load the same sw_s.
- upd: registered. It is 1 for exactly one cycle after any action, including clr. It does not fire for a load that leaves the value unchanged? No: it fires on every accepted action regardless of value.
- Status FSM states and transitions:
  - EMPTY: on a → HAVE_A, on b → HAVE_B, on a+b → READY.
  - HAVE_A: on b → READY.
  - HAVE_B: on a → READY.
  - READY: absorbing until clr.
  - clr from any state → EMPTY.
  - Reloading an operand already held keeps the current state.
- ready = (state == READY), decoded from the state register.

## Timing
- Reset values: a=0, b=0, upd=0, ready=0. State is EMPTY; all synchronizer, db, db_q and cnt flops are 0.
- Reset takes effect immediately. A reset asserted mid-debounce discards the partial count. A button held through reset release is seen as a new press after DB_COUNT+3 cycles.
- Latency: raw button rises and is captured at edge 1. Then:
  - edge 2: btn_s=1.
  - edge DB_COUNT+2: db=1.
  - edge DB_COUNT+3: a/b/state update and upd=1.
  - edge DB_COUNT+4: upd=0.
- sw must be stable for ≥3 cycles before the load edge. The value loaded is sw sampled 2 edges earlier.
- Holding a button produces exactly one action. A second action requires release, debounced for DB_COUNT cycles, followed by a new press.
- Presses on different buttons are independent; their pipelines may overlap.

## Test plan
- DB_COUNT=4 for all tests.
- Reset then idle 20 cycles → a=0, b=0, upd=0, ready=0.
- sw=3'b101, clean btn_a press held for 10 cycles → a=5 and upd=1 exactly 7 edges after the press, upd=0 the next cycle, ready=0, b unchanged.
- btn_b bouncing 1,0,1,0 every 2 cycles, then held high with sw=3'b011 → exactly one upd, b=3 loaded 7 edges after the last rising transition, ready=1 given A was loaded earlier.
- btn_a and btn_clr pressed on the same edge with sw=7 → a=0, b=0, ready=0, one upd pulse.
- btn_a and btn_b pressed on the same edge with sw=6 from EMPTY → a=6, b=6, ready=1 directly, one upd pulse.
- reset asserted 3 cycles into a btn_a debounce → outputs return to reset values immediately, and no load occurs after reset release while the button stays low.
